// File: rtl/string_stream_serializer.sv
// string_stream_serializer: buffers words via valid/ready, shifts them out MSB-first on string2, applies the 4-bit pattern on string1 at word boundaries
module string_stream_serializer #(
  parameter int WORD_W = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        pat_in,
  input  logic              pat_load,
  output logic [3:0]        string1,
  output logic              string2,
  output logic              bit_valid,
  output logic              busy,
  output logic [7:0]        words_sent
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(WORD_W);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t            r_state;
  logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wr_ptr, r_rd_ptr;
  logic [WORD_W-1:0] r_sr;
  logic [CW-1:0]     r_bit_cnt;
  logic [3:0]        r_pend;
  logic              r_pend_v;
  logic              w_empty, w_full, w_wr, w_last, w_pop, w_apply;
  logic [WORD_W-1:0] w_head;
  assign w_empty   = r_wr_ptr == r_rd_ptr;
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr      = in_valid && !w_full;
  assign w_last    = (r_state == SHIFT) && (r_bit_cnt == '0);
  assign w_pop     = !w_empty && ((r_state == IDLE) || w_last);
  assign w_apply   = r_pend_v && ((r_state == IDLE) || w_pop);
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign in_ready  = !w_full;
  assign busy      = (r_state == SHIFT) || !w_empty;
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_sr       <= '0;
      r_bit_cnt  <= '0;
      r_pend     <= '0;
      r_pend_v   <= 1'b0;
      string1    <= '0;
      string2    <= 1'b0;
      bit_valid  <= 1'b0;
      words_sent <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + (AW+1)'(1);
        r_sr      <= w_head;
        string2   <= w_head[WORD_W-1];
        bit_valid <= 1'b1;
        r_bit_cnt <= CW'(WORD_W-1);
        r_state   <= SHIFT;
      end else if (r_state == SHIFT && !w_last) begin
        r_sr      <= {r_sr[WORD_W-2:0], 1'b0};
        string2   <= r_sr[WORD_W-2];
        r_bit_cnt <= r_bit_cnt - CW'(1);
      end else begin
        r_state   <= IDLE;
        string2   <= 1'b0;
        bit_valid <= 1'b0;
      end
      if (w_last) words_sent <= words_sent + 8'd1;
      if (w_apply) string1 <= r_pend;
      if (pat_load) r_pend <= pat_in;
      r_pend_v <= pat_load || (r_pend_v && !w_apply);
    end
  end
endmodule

// File: tb/tb_string_stream_serializer.sv
// tb_string_stream_serializer: randomized and directed checks of string_stream_serializer against a queue-based reference model
module tb_string_stream_serializer;
  localparam int W = 8;
  localparam int DEPTH = 4;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   pat_in = '0;
  logic         pat_load = 1'b0;
  logic [3:0]   string1;
  logic         string2;
  logic         bit_valid;
  logic         busy;
  logic [7:0]   words_sent;
  string_stream_serializer #(.WORD_W(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .pat_in(pat_in), .pat_load(pat_load), .string1(string1), .string2(string2),
    .bit_valid(bit_valid), .busy(busy), .words_sent(words_sent)
  );
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] fq [$];
  bit           sq [$];
  logic [W-1:0] cur = '0;
  int           bits_left = 0;
  logic [3:0]   m_s1 = '0, m_pend = '0;
  logic         m_pend_v = 1'b0, m_s2 = 1'b0, m_bv = 1'b0;
  logic [7:0]   m_sent = '0, prev_ws = '0;
  logic [31:0]  obs = '0;
  int           run = 0, max_run = 0;
  logic         wrapped = 1'b0;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic model_edge();
    bit last, pop, acc, apply;
    if (rst) begin
      fq.delete(); sq.delete();
      bits_left = 0; m_s2 = 0; m_bv = 0; m_sent = 0; m_s1 = 0; m_pend = 0; m_pend_v = 0;
      return;
    end
    last  = bits_left == 1;
    pop   = fq.size() > 0 && (bits_left == 0 || last);
    acc   = in_valid && fq.size() < DEPTH;
    apply = m_pend_v && (bits_left == 0 || pop);
    if (apply) m_s1 = m_pend;
    if (pat_load) begin m_pend = pat_in; m_pend_v = 1; end
    else if (apply) m_pend_v = 0;
    if (last) m_sent++;
    if (pop) begin cur = fq.pop_front(); bits_left = W; end
    else if (bits_left > 0) bits_left--;
    m_bv = bits_left > 0;
    m_s2 = bits_left > 0 ? cur[bits_left-1] : 1'b0;
    if (acc) begin
      fq.push_back(in_data);
      for (int i = W-1; i >= 0; i--) sq.push_back(in_data[i]);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("string1", string1, m_s1);
    check("string2", string2, m_s2);
    check("bit_valid", bit_valid, m_bv);
    check("busy", busy, (bits_left > 0 || fq.size() > 0));
    check("in_ready", in_ready, fq.size() < DEPTH);
    check("words_sent", words_sent, m_sent);
    if (bit_valid) begin
      if (sq.size() == 0) check("stream_extra", 1, 0);
      else check("stream", string2, sq.pop_front());
      obs = {obs[30:0], string2};
      run++;
      if (run > max_run) max_run = run;
    end else run = 0;
    if (prev_ws == 8'd255 && words_sent == 8'd0) wrapped = 1'b1;
    prev_ws = words_sent;
  endtask
  task automatic push(input logic [W-1:0] d);
    in_valid = 1'b1; in_data = d; tick(); in_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask
  initial begin
    idle(2);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_string1", string1, 0);
    // single word with pattern
    pat_in = 4'b0110; pat_load = 1'b1; tick(); pat_load = 1'b0;
    obs = '0;
    push(8'h66);
    idle(12);
    check("t1_bits", obs[7:0], 8'h66);
    check("t1_string1", string1, 4'b0110);
    check("t1_sent", words_sent, 1);
    check("t1_busy", busy, 0);
    // back-to-back
    obs = '0; max_run = 0;
    in_valid = 1'b1;
    in_data = 8'hA5; tick();
    in_data = 8'h3C; tick();
    in_data = 8'hFF; tick();
    in_data = 8'h00; tick();
    in_valid = 1'b0;
    idle(40);
    check("t2_bits", obs, 32'hA53CFF00);
    check("t2_run", max_run, 32);
    check("t2_sent", words_sent, 5);
    // overflow: in_valid held with changing data while shifter busy
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin in_data = 8'($urandom); tick(); end
    in_valid = 1'b0;
    idle(60);
    check("t3_sent", words_sent, 10);
    // mid-word pattern change
    pat_in = 4'b0110; pat_load = 1'b1; tick(); pat_load = 1'b0;
    in_valid = 1'b1; in_data = 8'h66; tick(); in_data = 8'h99; tick(); in_valid = 1'b0;
    idle(4);
    pat_in = 4'b1001; pat_load = 1'b1; tick(); pat_load = 1'b0;
    tick();
    check("t4_hold", string1, 4'b0110);
    idle(3);
    check("t4_new", string1, 4'b1001);
    idle(12);
    // reset mid-word with two words queued
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin in_data = 8'($urandom); tick(); end
    in_valid = 1'b0;
    tick();
    do_reset();
    check("t5_string2", string2, 0);
    check("t5_bit_valid", bit_valid, 0);
    check("t5_sent", words_sent, 0);
    check("t5_string1", string1, 0);
    check("t5_in_ready", in_ready, 1);
    max_run = 0;
    idle(20);
    check("t5_quiet", max_run, 0);
    // randomized streaming, long enough to wrap words_sent
    for (int c = 0; c < 3000; c++) begin
      in_valid = $urandom_range(3, 0) != 0;
      in_data  = 8'($urandom);
      pat_load = $urandom_range(7, 0) == 0;
      pat_in   = 4'($urandom);
      tick();
    end
    in_valid = 1'b0; pat_load = 1'b0;
    idle(50);
    check("wrap_seen", wrapped, 1);
    check("drained", sq.size(), 0);
    check("end_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
